// File: rtl/pe_slice_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_slice_sequencer_if
//
// Bundles the two handshakes of the slice sequencer:
//   - operand side : in_valid / in_ready, in_0, in_1, prec_0, prec_1
//   - brick side   : out_valid / out_ready, out_0, out_1, out_shift,
//                    out_sel, out_last
//
// Modports:
//   slave  - the sequencer itself (accepts operands, issues bricks)
//   master - the environment around it (operand buffer upstream and the
//            PE downstream, seen as one party)
// ---------------------------------------------------------------------------
interface pe_slice_sequencer_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int SLICE_WIDTH = 2,
   parameter int ACC_WIDTH   = 16
);
   localparam int NUM_SLICES  = DATA_WIDTH / SLICE_WIDTH;
   localparam int PREC_WIDTH  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH);

   // Operand handshake
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  in_0;
   logic [DATA_WIDTH-1:0]  in_1;
   logic [PREC_WIDTH-1:0]  prec_0;
   logic [PREC_WIDTH-1:0]  prec_1;

   // Brick handshake
   logic                   out_valid;
   logic                   out_ready;
   logic [SLICE_WIDTH-1:0] out_0;
   logic [SLICE_WIDTH-1:0] out_1;
   logic [SHIFT_WIDTH-1:0] out_shift;
   logic                   out_sel;
   logic                   out_last;

   modport slave (
      input  in_valid, in_0, in_1, prec_0, prec_1, out_ready,
      output in_ready, out_valid, out_0, out_1, out_shift, out_sel, out_last
   );

   modport master (
      output in_valid, in_0, in_1, prec_0, prec_1, out_ready,
      input  in_ready, out_valid, out_0, out_1, out_shift, out_sel, out_last
   );
endinterface

// File: rtl/pe_slice_sequencer.sv
// ---------------------------------------------------------------------------
// pe_slice_sequencer
//
// Splits one pair of unsigned operands into SLICE_WIDTH-bit bricks and issues
// every brick pair (i outer, j inner) to the PE, one pair per cycle, along
// with the shift (i+j)*SLICE_WIDTH and an accumulate-select. The PE rebuilds
// the full product by summing out_0*out_1 << out_shift over the transaction.
// Precision per operand is chosen per transaction via prec_0 / prec_1
// (active slices minus one); slices above the precision are never issued.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; returns to IDLE, clears operands
//   bus    - pe_slice_sequencer_if.slave:
//              in_valid/in_ready, in_0, in_1, prec_0, prec_1  (operand side)
//              out_valid/out_ready, out_0, out_1, out_shift,
//              out_sel, out_last                              (brick side)
//
// All brick-side outputs are registered. in_ready is the only combinational
// output: it also rises on the cycle the final pair is consumed, so a new
// operand pair can follow without a bubble.
// ---------------------------------------------------------------------------
module pe_slice_sequencer #(
   parameter int DATA_WIDTH  = 8,
   parameter int SLICE_WIDTH = 2,
   parameter int ACC_WIDTH   = 16
) (
   input logic                clk,
   input logic                reset,
   pe_slice_sequencer_if.slave bus
);
   localparam int NUM_SLICES  = DATA_WIDTH / SLICE_WIDTH;
   localparam int PREC_WIDTH  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e                 state_q,     state_d;
   logic [DATA_WIDTH-1:0]  a_q,         a_d;
   logic [DATA_WIDTH-1:0]  b_q,         b_d;
   logic [PREC_WIDTH-1:0]  p0_q,        p0_d;
   logic [PREC_WIDTH-1:0]  p1_q,        p1_d;
   // (i_q, j_q) is the pair currently presented on the outputs.
   logic [PREC_WIDTH-1:0]  i_q,         i_d;
   logic [PREC_WIDTH-1:0]  j_q,         j_d;
   logic [SLICE_WIDTH-1:0] out_0_q,     out_0_d;
   logic [SLICE_WIDTH-1:0] out_1_q,     out_1_d;
   logic [SHIFT_WIDTH-1:0] out_shift_q, out_shift_d;
   logic                   out_sel_q,   out_sel_d;
   logic                   out_last_q,  out_last_d;

   logic                   out_valid;
   logic                   in_ready;
   logic                   in_fire;
   logic                   out_fire;
   logic                   load_pair;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   // Slice k of v, slice 0 at the LSB.
   function automatic logic [SLICE_WIDTH-1:0] slice_of(
      input logic [DATA_WIDTH-1:0] v,
      input logic [PREC_WIDTH-1:0] k
   );
      logic [DATA_WIDTH-1:0] shifted;
      shifted = v >> (int'(k) * SLICE_WIDTH);
      return shifted[SLICE_WIDTH-1:0];
   endfunction

   // Weight of brick pair (i, j) in the accumulator. The largest value,
   // 2*(NUM_SLICES-1)*SLICE_WIDTH, always fits because ACC_WIDTH covers a
   // full 2*DATA_WIDTH product.
   function automatic logic [SHIFT_WIDTH-1:0] shift_of(
      input logic [PREC_WIDTH-1:0] i,
      input logic [PREC_WIDTH-1:0] j
   );
      int s;
      s = (int'(i) + int'(j)) * SLICE_WIDTH;
      return SHIFT_WIDTH'(s);
   endfunction

   // ------------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------------
   // The state bit is itself a register, so out_valid stays registered.
   assign out_valid = (state_q == ISSUE);
   assign out_fire  = out_valid && bus.out_ready;
   // Ready in IDLE, or while the final pair is being consumed (no bubble).
   assign in_ready  = (state_q == IDLE) || (out_fire && out_last_q);
   assign in_fire   = bus.in_valid && in_ready;

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets its hold value first so no path through
      // this block leaves one unassigned, which would infer a latch.
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      p0_d        = p0_q;
      p1_d        = p1_q;
      i_d         = i_q;
      j_d         = j_q;
      out_0_d     = out_0_q;
      out_1_d     = out_1_q;
      out_shift_d = out_shift_q;
      out_sel_d   = out_sel_q;
      out_last_d  = out_last_q;
      load_pair   = 1'b0;

      if (in_fire) begin
         // New operand pair; in ISSUE this only happens on the final pair's
         // transfer, so the previous transaction is already complete.
         state_d   = ISSUE;
         a_d       = bus.in_0;
         b_d       = bus.in_1;
         p0_d      = bus.prec_0;
         p1_d      = bus.prec_1;
         i_d       = '0;
         j_d       = '0;
         load_pair = 1'b1;
      end else if (out_fire) begin
         if (out_last_q) begin
            state_d = IDLE;
         end else if (j_q == p1_q) begin
            i_d       = i_q + PREC_WIDTH'(1);
            j_d       = '0;
            load_pair = 1'b1;
         end else begin
            j_d       = j_q + PREC_WIDTH'(1);
            load_pair = 1'b1;
         end
      end

      // Outputs change only when a new pair is presented; a stall or an
      // idle period leaves them at their last values.
      if (load_pair) begin
         out_0_d     = slice_of(a_d, i_d);
         out_1_d     = slice_of(b_d, j_d);
         out_shift_d = shift_of(i_d, j_d);
         out_sel_d   = (i_d != '0) || (j_d != '0);
         out_last_d  = (i_d == p0_d) && (j_d == p1_d);
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the operand latches are reset too, so a transaction cut
         // short by reset leaves nothing behind to leak into the next one.
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         p0_q        <= '0;
         p1_q        <= '0;
         i_q         <= '0;
         j_q         <= '0;
         out_0_q     <= '0;
         out_1_q     <= '0;
         out_shift_q <= '0;
         out_sel_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         p0_q        <= p0_d;
         p1_q        <= p1_d;
         i_q         <= i_d;
         j_q         <= j_d;
         out_0_q     <= out_0_d;
         out_1_q     <= out_1_d;
         out_shift_q <= out_shift_d;
         out_sel_q   <= out_sel_d;
         out_last_q  <= out_last_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_0     = out_0_q;
   assign bus.out_1     = out_1_q;
   assign bus.out_shift = out_shift_q;
   assign bus.out_sel   = out_sel_q;
   assign bus.out_last  = out_last_q;

   // ------------------------------------------------------------------------
   // Properties
   // ------------------------------------------------------------------------
   // A stalled pair is held unchanged until the PE takes it.
   stall_hold_a : assert property (@(posedge clk) disable iff (reset)
      (out_valid && !bus.out_ready) |=>
         (out_valid && $stable(out_0_q) && $stable(out_1_q) &&
          $stable(out_shift_q) && $stable(out_sel_q) && $stable(out_last_q)));

   // A pair that is both first and last only exists for a 1x1 transaction.
   single_pair_a : assert property (@(posedge clk) disable iff (reset)
      (out_valid && out_last_q && !out_sel_q) |->
         ((p0_q == '0) && (p1_q == '0)));
endmodule

// File: tb/tb_pe_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_slice_sequencer
//
// Directed bench for pe_slice_sequencer at default parameters (8-bit
// operands, 2-bit slices, 16-bit accumulator). A table of operand pairs with
// hand-computed pair counts, first/last bricks and reconstructed products
// drives a transaction runner; back-to-back issue and mid-transaction reset
// are written out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_pe_slice_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   pe_slice_sequencer_if #(.DATA_WIDTH(8), .SLICE_WIDTH(2), .ACC_WIDTH(16)) bus ();

   pe_slice_sequencer #(.DATA_WIDTH(8), .SLICE_WIDTH(2), .ACC_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] p0;
      logic [1:0] p1;
      int         stall_at;    // pair index to stall on (-1: none)
      int         stall_len;   // cycles with out_ready low
      int         exp_cycles;  // valid cycles incl. stalls
      int         exp_sum;     // sum of out_0*out_1 << out_shift
      logic [1:0] f0, f1;      // first pair bricks
      logic [1:0] l0, l1;      // last pair bricks
   } vec_t;

   // Expected brick k of an operand, independent of the DUT.
   function automatic logic [1:0] brick(input logic [7:0] v, input int k);
      logic [7:0] t;
      t = v >> (2 * k);
      return t[1:0];
   endfunction

   // Runs one transaction from IDLE, checking every presented pair.
   task automatic run_txn(input vec_t v);
      int   pairs, p, cycles, stall_cnt, sum, i, j;
      logic ready, done;
      pairs     = (int'(v.p0) + 1) * (int'(v.p1) + 1);
      p         = 0;
      cycles    = 0;
      stall_cnt = 0;
      sum       = 0;
      done      = 1'b0;

      @(negedge clk);
      bus.in_0      = v.a;
      bus.in_1      = v.b;
      bus.prec_0    = v.p0;
      bus.prec_1    = v.p1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1 check({v.name, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);

      @(negedge clk);
      // Scramble the inputs to show the operands were latched.
      bus.in_valid = 1'b0;
      bus.in_0     = ~v.a;
      bus.in_1     = ~v.b;
      bus.prec_0   = ~v.p0;
      bus.prec_1   = ~v.p1;

      while (!done && cycles < 100) begin
         ready = !(p == v.stall_at && stall_cnt < v.stall_len);
         bus.out_ready = ready;
         #1;
         i = p / (int'(v.p1) + 1);
         j = p % (int'(v.p1) + 1);
         check($sformatf("%s p%0d valid", v.name, p), 32'(bus.out_valid), 32'd1);
         check($sformatf("%s p%0d out_0", v.name, p), 32'(bus.out_0), 32'(brick(v.a, i)));
         check($sformatf("%s p%0d out_1", v.name, p), 32'(bus.out_1), 32'(brick(v.b, j)));
         check($sformatf("%s p%0d shift", v.name, p), 32'(bus.out_shift), 32'((i + j) * 2));
         check($sformatf("%s p%0d sel", v.name, p), 32'(bus.out_sel), 32'(p != 0));
         check($sformatf("%s p%0d last", v.name, p), 32'(bus.out_last), 32'(p == pairs - 1));
         check($sformatf("%s p%0d in_ready", v.name, p), 32'(bus.in_ready),
               32'((p == pairs - 1) && ready));
         if (p == 0) begin
            check({v.name, " first_out_0"}, 32'(bus.out_0), 32'(v.f0));
            check({v.name, " first_out_1"}, 32'(bus.out_1), 32'(v.f1));
         end
         if (p == pairs - 1) begin
            check({v.name, " last_out_0"}, 32'(bus.out_0), 32'(v.l0));
            check({v.name, " last_out_1"}, 32'(bus.out_1), 32'(v.l1));
         end
         cycles++;
         if (ready) begin
            sum += (int'(bus.out_0) * int'(bus.out_1)) << bus.out_shift;
            p++;
            if (p == pairs) done = 1'b1;
         end else begin
            stall_cnt++;
         end
         if (!done) @(negedge clk);
      end
      if (!done) check({v.name, " timeout"}, 32'd0, 32'd1);

      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
      check({v.name, " valid_after"},    32'(bus.out_valid), 32'd0);
      check({v.name, " in_ready_after"}, 32'(bus.in_ready),  32'd1);
      check({v.name, " cycles"},         32'(cycles),        32'(v.exp_cycles));
      check({v.name, " sum"},            32'(sum),           32'(v.exp_sum));
   endtask

   vec_t vecs[6];

   initial begin
      //         name       a      b      p0 p1 st len cyc  sum      f0 f1 l0 l1
      vecs[0] = '{"full",  8'hB7, 8'h5C, 3, 3, -1, 0, 16, 'h41C4, 3, 0, 2, 1};
      vecs[1] = '{"min",   8'hFF, 8'hFE, 0, 0, -1, 0,  1, 6,      3, 2, 3, 2};
      vecs[2] = '{"mixed", 8'h9C, 8'hA5, 3, 1, -1, 0,  8, 'h30C,  0, 1, 2, 1};
      vecs[3] = '{"p1x2",  8'h3C, 8'h0F, 1, 2, -1, 0,  6, 180,    0, 3, 3, 0};
      vecs[4] = '{"maxv",  8'hFF, 8'hFF, 3, 3, -1, 0, 16, 'hFE01, 3, 3, 3, 3};
      vecs[5] = '{"stall", 8'hB7, 8'h5C, 3, 3,  5, 3, 19, 'h41C4, 3, 0, 2, 1};

      bus.in_valid  = 1'b0;
      bus.in_0      = '0;
      bus.in_1      = '0;
      bus.prec_0    = '0;
      bus.prec_1    = '0;
      bus.out_ready = 1'b1;

      // Reset values
      #12;
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst out_0",     32'(bus.out_0),     32'd0);
      check("rst out_1",     32'(bus.out_1),     32'd0);
      check("rst out_shift", 32'(bus.out_shift), 32'd0);
      check("rst out_sel",   32'(bus.out_sel),   32'd0);
      check("rst out_last",  32'(bus.out_last),  32'd0);
      check("rst in_ready",  32'(bus.in_ready),  32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1 check("post_rst in_ready", 32'(bus.in_ready), 32'd1);

      for (int k = 0; k < 6; k++) run_txn(vecs[k]);

      // Back-to-back: two 2x2 transactions with in_valid held high.
      begin
         logic [7:0] ta[2];
         logic [7:0] tb[2];
         int         sums[2];
         int         exp_sums[2];
         int         t, p, i, j;
         ta[0] = 8'h0D; tb[0] = 8'h0B; exp_sums[0] = 143;
         ta[1] = 8'h06; tb[1] = 8'h09; exp_sums[1] = 54;
         sums[0] = 0; sums[1] = 0;
         @(negedge clk);
         bus.in_0 = ta[0]; bus.in_1 = tb[0];
         bus.prec_0 = 2'd1; bus.prec_1 = 2'd1;
         bus.in_valid = 1'b1; bus.out_ready = 1'b1;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 3) begin
               bus.in_0 = ta[1];
               bus.in_1 = tb[1];
            end
            if (c == 4) bus.in_valid = 1'b0;
            #1;
            t = c / 4; p = c % 4; i = p / 2; j = p % 2;
            check($sformatf("b2b c%0d valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("b2b c%0d out_0", c), 32'(bus.out_0), 32'(brick(ta[t], i)));
            check($sformatf("b2b c%0d out_1", c), 32'(bus.out_1), 32'(brick(tb[t], j)));
            check($sformatf("b2b c%0d sel", c),   32'(bus.out_sel), 32'(p != 0));
            check($sformatf("b2b c%0d last", c),  32'(bus.out_last), 32'(p == 3));
            check($sformatf("b2b c%0d in_ready", c), 32'(bus.in_ready), 32'(p == 3));
            sums[t] += (int'(bus.out_0) * int'(bus.out_1)) << bus.out_shift;
         end
         @(negedge clk);
         #1 check("b2b valid_after", 32'(bus.out_valid), 32'd0);
         check("b2b sum0", 32'(sums[0]), 32'(exp_sums[0]));
         check("b2b sum1", 32'(sums[1]), 32'(exp_sums[1]));
      end

      // Asynchronous reset at pair 7 of a full-precision run.
      @(negedge clk);
      bus.in_0 = 8'hB7; bus.in_1 = 8'h5C;
      bus.prec_0 = 2'd3; bus.prec_1 = 2'd3;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      check("rst_mid p7 out_0", 32'(bus.out_0),     32'd1);
      check("rst_mid p7 out_1", 32'(bus.out_1),     32'd1);
      check("rst_mid p7 shift", 32'(bus.out_shift), 32'd8);
      #2 reset = 1'b1;
      #1;
      check("rst_mid out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mid in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_mid out_0",     32'(bus.out_0),     32'd0);
      @(negedge clk);
      reset = 1'b0;
      begin
         vec_t fresh;
         fresh = vecs[2];
         fresh.name = "after_rst";
         run_txn(fresh);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard bound in case the clocked sequence itself stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pe_slice_sequencer.md
# pe_slice_sequencer

Decomposes one pair of unsigned fixed-point operands into SLICE_WIDTH-bit bricks. Issues every brick pair, one per cycle, to the PE multiply/shift/accumulate stage, together with the matching shift amount and accumulate-select. The PE accumulator thereby rebuilds the full-precision product over several cycles. Per-operand precision is chosen per transaction, so low-precision operands take proportionally fewer cycles. The block sits directly upstream of the PE: operand buffer → pe_slice_sequencer → PE.

## Interface
- DATA_WIDTH, 8: full operand width; must be a multiple of SLICE_WIDTH.
- SLICE_WIDTH, 2: brick width fed to the PE multiplier.
- ACC_WIDTH, 16: PE accumulator width; must be at least 2*DATA_WIDTH.
- NUM_SLICES, DATA_WIDTH/SLICE_WIDTH: bricks per full-precision operand.
- PREC_WIDTH, max(1,$clog2(NUM_SLICES)): width of each precision field.
- SHIFT_WIDTH, $clog2(ACC_WIDTH): width of the shift output.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_0  input  DATA_WIDTH  operand A, unsigned.
- in_1  input  DATA_WIDTH  operand B, unsigned.
- prec_0  input  PREC_WIDTH  active slices of in_0 minus 1.
- prec_1  input  PREC_WIDTH  active slices of in_1 minus 1.
- out_valid  output  1  brick pair valid.
- out_ready  input  1  downstream accepts the brick pair (array stall when low).
- out_0  output  SLICE_WIDTH  slice i of latched in_0.
- out_1  output  SLICE_WIDTH  slice j of latched in_1.
- out_shift  output  SHIFT_WIDTH  (i+j)*SLICE_WIDTH.
- out_sel  output  1  0 = first pair (accumulator loads); 1 = accumulate.
- out_last  output  1  final pair of the current operand pair.

## Operation
- States: IDLE and ISSUE.
- Input handshake: a transfer occurs when in_valid && in_ready. The transfer latches in_0, in_1, prec_0 and prec_1, sets i=j=0, and enters ISSUE.
- Output handshake: an output transfer occurs when out_valid && out_ready.
- Slice definition: slice k is bits [k*SLICE_WIDTH +: SLICE_WIDTH]; slice 0 is the LSB.
- Issue order: i (operand A slice) is the outer loop, 0..prec_0; j (operand B slice) is the inner loop, 0..prec_1.
- Pair count: (prec_0+1)*(prec_1+1) pairs are issued.
- Bits above the selected precision are ignored, i.e. treated as zero.
- out_sel is 0 only on pair (0,0) and 1 on all others.
- out_last is 1 only on pair (prec_0,prec_1). A single-pair transaction has out_sel=0 and out_last=1 together.
- out_shift always fits: the maximum is 2*(NUM_SLICES-1)*SLICE_WIDTH < ACC_WIDTH.
- in_ready = (state==IDLE) || (out_valid && out_last && out_ready). in_ready is combinational, and this term is the only combinational path.
- Back-to-back: if a new input transfers on the cycle the last pair transfers, the sequencer stays in ISSUE and issues the new pair (0,0) next cycle with no bubble.
- If the last pair transfers and no new input is pending, the sequencer returns to IDLE and out_valid falls.
- Stall: while out_valid && !out_ready, all out_* hold their values and the counters do not advance.
- Reset, including mid-transaction: forces IDLE and discards the latched operands.

## Timing
- All out_* are registered.
- Reset values: out_valid=0, out_0=0, out_1=0, out_shift=0, out_sel=0, out_last=0, in_ready=1.
- Latency: an input accepted at edge k presents pair (0,0) from edge k until edge k+1.
- Throughput: one pair per cycle while out_ready=1.
- Occupancy: a transaction occupies exactly (prec_0+1)*(prec_1+1) cycles with no stalls.
- out_0, out_1, out_shift, out_sel and out_last are don't-care when out_valid=0. They are held at their last values, with zeros after reset.
- The PE result for a transaction is complete one cycle after its out_last pair is consumed; the sequencer does not track this.

## Test plan
- Full precision, default parameters: in_0=0xB7, in_1=0x5C, prec_0=prec_1=3 with out_ready=1. Required: 16 consecutive pairs, shifts 0,2,4,6,2,4,6,8,…,12. The first pair is out_0=3, out_1=0, sel=0; the last is out_0=2, out_1=1, last=1. A reference model that sums out_0*out_1<<out_shift gives 0x41C4.
- Minimum precision: in_0=0xFF, in_1=0xFE, prec_0=prec_1=0. Required: exactly one pair, out_0=3, out_1=2, shift=0, sel=0, last=1. in_ready is high again in the same cycle.
- Mixed precision: in_0=0x9C, in_1=0xA5, prec_0=3, prec_1=1. Required: 8 pairs; the model sum equals 0x9C*0x05=0x30C, because the upper bits of in_1 are ignored.
- Back-to-back with in_valid held high for two transactions of 4 pairs each (prec 1/1). Required: 8 consecutive valid cycles; the second transaction's sel=0 appears in the cycle after the first transaction's last=1.
- Stall: full-precision run with out_ready=0 for 3 cycles at pair 5. Required: pair 5 held unchanged for 4 cycles, 19 total valid cycles, and the sum is unchanged.
- Reset asserted asynchronously at pair 7, between clock edges. Required: out_valid=0 and in_ready=1 immediately. A fresh transaction after release starts at pair (0,0) with sel=0.
